// File: rtl/multi_timer_pkg.sv
// Shared types and constants for the multi-channel seconds countdown timer.
package multi_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } chan_state_t;

  localparam int DEFAULT_LOAD_SEC = 60;

endpackage

// File: rtl/multi_timer_tick_gen.sv
// Free-running seconds prescaler: counts 0..CLK_HZ-1 and strobes tick while at CLK_HZ-1.
module tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [CW-1:0] w_cnt_next;

  assign w_cnt_next = (r_cnt == LP_LAST) ? '0 : r_cnt + CW'(1);

  // tick is registered from the next count so it is high exactly while r_cnt == CLK_HZ-1
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= (w_cnt_next == LP_LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/multi_timer.sv
// NCH independent countdown channels driven by one shared seconds prescaler.
// Optional per-channel auto-reload on expiry is enabled by defining MULTI_TIMER_AUTORELOAD_EN.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int NCH          = 4,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_LOAD = DEFAULT_LOAD_SEC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       start,
  input  logic [NCH*CNT_W-1:0] load_val,
  input  logic [NCH-1:0]       pause,
`ifdef MULTI_TIMER_AUTORELOAD_EN
  input  logic [NCH-1:0]       autoreload,
`endif
  output logic [NCH*CNT_W-1:0] activetime,
  output logic [NCH-1:0]       expired,
  output logic [NCH-1:0]       expire_pulse,
  output logic                 tick
);

  localparam logic [CNT_W-1:0] LP_DEF_LOAD = CNT_W'(DEFAULT_LOAD);
  localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);

  logic w_tick;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign tick = w_tick;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      chan_state_t      r_state;
      logic [CNT_W-1:0] r_cnt;
      logic             r_expired;
      logic             r_pulse;
      logic [CNT_W-1:0] w_load_val;
      logic [CNT_W-1:0] w_load;
      logic             w_reload_now;
      logic [CNT_W-1:0] w_reload_val;

      assign w_load_val = load_val[gi*CNT_W +: CNT_W];
      assign w_load     = (w_load_val == '0) ? LP_DEF_LOAD : w_load_val;

`ifdef MULTI_TIMER_AUTORELOAD_EN
      logic [CNT_W-1:0] r_reload;

      always_ff @(posedge clk) begin
        if (reset)           r_reload <= '0;
        else if (start[gi])  r_reload <= w_load;
      end

      assign w_reload_now = autoreload[gi];
      assign w_reload_val = r_reload;
`else
      assign w_reload_now = 1'b0;
      assign w_reload_val = '0;
`endif

      // Priority: reset > start > pause > tick. A count at 0 or 1 on a tick expires, so it never wraps.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_expired <= 1'b0;
          r_pulse   <= 1'b0;
        end else begin
          r_pulse <= 1'b0;
          if (start[gi]) begin
            r_cnt     <= w_load;
            r_expired <= 1'b0;
            r_state   <= ST_RUN;
          end else begin
            case (r_state)
              ST_RUN: begin
                if (pause[gi]) begin
                  r_state <= ST_PAUSED;
                end else if (w_tick) begin
                  if (r_cnt > LP_ONE) begin
                    r_cnt <= r_cnt - LP_ONE;
                  end else begin
                    r_pulse <= 1'b1;
                    if (w_reload_now) begin
                      r_cnt <= w_reload_val;
                    end else begin
                      r_cnt     <= '0;
                      r_expired <= 1'b1;
                      r_state   <= ST_EXPIRED;
                    end
                  end
                end
              end
              ST_PAUSED: begin
                if (!pause[gi]) r_state <= ST_RUN;
              end
              default: ;
            endcase
          end
        end
      end

      assign activetime[gi*CNT_W +: CNT_W] = r_cnt;
      assign expired[gi]                   = r_expired;
      assign expire_pulse[gi]              = r_pulse;
    end
  endgenerate

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer with CLK_HZ=4, NCH=2, CNT_W=8; inputs driven and outputs sampled on negedge.
module tb_multi_timer;

  localparam int CLK_HZ = 4;
  localparam int NCH    = 2;
  localparam int CNT_W  = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       start;
  logic [NCH*CNT_W-1:0] load_val;
  logic [NCH-1:0]       pause;
  logic [NCH*CNT_W-1:0] activetime;
  logic [NCH-1:0]       expired;
  logic [NCH-1:0]       expire_pulse;
  logic                 tick;
`ifdef MULTI_TIMER_AUTORELOAD_EN
  logic [NCH-1:0]       autoreload;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_timer #(.CLK_HZ(CLK_HZ), .NCH(NCH), .CNT_W(CNT_W), .DEFAULT_LOAD(60)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_val     (load_val),
    .pause        (pause),
`ifdef MULTI_TIMER_AUTORELOAD_EN
    .autoreload   (autoreload),
`endif
    .activetime   (activetime),
    .expired      (expired),
    .expire_pulse (expire_pulse),
    .tick         (tick)
  );

  // Caller sits at a negedge; returns at the negedge where tick is high (consumed by the next posedge).
  task automatic wait_tick(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (tick === 1'b1) return;
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: tick not seen within 20 cycles (got 0, required 1)", tag);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = '0; load_val = '0; pause = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start = 2'b01; load_val = 16'h0005;
    @(negedge clk);
    start = '0;
    n_checks++;
    if (activetime[7:0] !== 8'd5) begin
      n_fail++; $display("FAIL reset_preload: act0 got %0d required 5", activetime[7:0]);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (activetime !== 16'h0000) begin
      n_fail++; $display("FAIL reset_act: got %h required 0000", activetime);
    end
    n_checks++;
    if (expired !== 2'b00 || expire_pulse !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: expired %b pulse %b required 00 00", expired, expire_pulse);
    end
    n_checks++;
    if (tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_tick: got %b required 0", tick);
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (tick !== ((k % 4) == 3)) begin
        n_fail++; $display("FAIL tick_period k=%0d: got %b required %b", k, tick, (k % 4) == 3);
      end
    end
    n_checks++;
    if (activetime !== 16'h0000) begin
      n_fail++; $display("FAIL idle_ignores_tick: got %h required 0000", activetime);
    end
    $display("test_reset done");
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'd2; exp_seq[1] = 8'd1; exp_seq[2] = 8'd0;
    start = 2'b01; load_val = 16'h0003;
    @(negedge clk);
    start = '0;
    n_checks++;
    if (activetime[7:0] !== 8'd3) begin
      n_fail++; $display("FAIL oneshot_load: got %0d required 3", activetime[7:0]);
    end
    for (int s = 0; s < 3; s++) begin
      wait_tick("oneshot");
      @(negedge clk);
      n_checks++;
      if (activetime[7:0] !== exp_seq[s]) begin
        n_fail++; $display("FAIL oneshot_step%0d: got %0d required %0d", s, activetime[7:0], exp_seq[s]);
      end
      n_checks++;
      if (expire_pulse[0] !== (s == 2) || expired[0] !== (s == 2)) begin
        n_fail++; $display("FAIL oneshot_flags%0d: pulse %b expired %b required %b", s, expire_pulse[0], expired[0], s == 2);
      end
    end
    @(negedge clk);
    n_checks++;
    if (expire_pulse[0] !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_pulse_width: got %b required 0", expire_pulse[0]);
    end
    wait_tick("oneshot_hold");
    @(negedge clk);
    n_checks++;
    if (activetime[7:0] !== 8'd0 || expired[0] !== 1'b1 || expire_pulse[0] !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_hold: act %0d expired %b pulse %b required 0 1 0", activetime[7:0], expired[0], expire_pulse[0]);
    end
    n_checks++;
    if (activetime[15:8] !== 8'd0 || expired[1] !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_ch1: act %0d expired %b required 0 0", activetime[15:8], expired[1]);
    end
    $display("test_oneshot done");
  endtask

  task automatic test_default_load();
    start = 2'b10; load_val = 16'h0000;
    @(negedge clk);
    start = '0;
    n_checks++;
    if (activetime[15:8] !== 8'd60) begin
      n_fail++; $display("FAIL default_load: got %0d required 60", activetime[15:8]);
    end
    n_checks++;
    if (activetime[7:0] !== 8'd0 || expired[0] !== 1'b1) begin
      n_fail++; $display("FAIL default_ch0: act %0d expired %b required 0 1", activetime[7:0], expired[0]);
    end
    wait_tick("default");
    @(negedge clk);
    n_checks++;
    if (activetime[15:8] !== 8'd59) begin
      n_fail++; $display("FAIL default_dec: got %0d required 59", activetime[15:8]);
    end
    $display("test_default_load done");
  endtask

  task automatic test_pause();
    start = 2'b01; load_val = 16'h0005;
    @(negedge clk);
    start = '0;
    pause = 2'b01;
    for (int t = 0; t < 3; t++) begin
      wait_tick("pause");
      @(negedge clk);
      n_checks++;
      if (activetime[7:0] !== 8'd5) begin
        n_fail++; $display("FAIL pause_hold%0d: got %0d required 5", t, activetime[7:0]);
      end
    end
    pause = 2'b00;
    wait_tick("resume");
    @(negedge clk);
    n_checks++;
    if (activetime[7:0] !== 8'd4) begin
      n_fail++; $display("FAIL pause_resume: got %0d required 4", activetime[7:0]);
    end
    $display("test_pause done");
  endtask

  task automatic test_start_on_tick();
    wait_tick("sot_a");
    @(negedge clk);
    wait_tick("sot_b");
    @(negedge clk);
    n_checks++;
    if (activetime[7:0] !== 8'd2) begin
      n_fail++; $display("FAIL sot_pre: got %0d required 2", activetime[7:0]);
    end
    wait_tick("sot_c");
    start = 2'b01; load_val = 16'h0007;
    @(negedge clk);
    start = '0;
    n_checks++;
    if (activetime[7:0] !== 8'd7 || expire_pulse[0] !== 1'b0) begin
      n_fail++; $display("FAIL start_on_tick: act %0d pulse %b required 7 0", activetime[7:0], expire_pulse[0]);
    end
    start = 2'b01; load_val = 16'h0001;
    @(negedge clk);
    start = '0;
    wait_tick("sot_exp");
    @(negedge clk);
    n_checks++;
    if (expired[0] !== 1'b1 || activetime[7:0] !== 8'd0) begin
      n_fail++; $display("FAIL sot_expire: expired %b act %0d required 1 0", expired[0], activetime[7:0]);
    end
    start = 2'b01; load_val = 16'h0004;
    @(negedge clk);
    start = '0;
    n_checks++;
    if (expired[0] !== 1'b0 || activetime[7:0] !== 8'd4) begin
      n_fail++; $display("FAIL restart_expired: expired %b act %0d required 0 4", expired[0], activetime[7:0]);
    end
    $display("test_start_on_tick done");
  endtask

`ifdef MULTI_TIMER_AUTORELOAD_EN
  task automatic test_autoreload();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'd1; exp_seq[1] = 8'd2; exp_seq[2] = 8'd1; exp_seq[3] = 8'd2;
    autoreload = 2'b01;
    start = 2'b01; load_val = 16'h0002;
    @(negedge clk);
    start = '0;
    for (int s = 0; s < 4; s++) begin
      wait_tick("autoreload");
      @(negedge clk);
      n_checks++;
      if (activetime[7:0] !== exp_seq[s] || expire_pulse[0] !== (s % 2 == 1) || expired[0] !== 1'b0) begin
        n_fail++; $display("FAIL autoreload%0d: act %0d pulse %b expired %b required %0d %b 0",
                           s, activetime[7:0], expire_pulse[0], expired[0], exp_seq[s], s % 2 == 1);
      end
    end
    autoreload = 2'b00;
    $display("test_autoreload done");
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = '0; load_val = '0; pause = '0;
`ifdef MULTI_TIMER_AUTORELOAD_EN
    autoreload = '0;
`endif
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_default_load();
    test_pause();
    test_start_on_tick();
`ifdef MULTI_TIMER_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
